// File: rtl/lcd_char_ctrl.sv
// HD44780-style character LCD write controller: power-up wait, init sequence,
// byte/nibble strobing with per-command settle waits and automatic line wrap.
module lcd_char_ctrl #(
    parameter int unsigned BUS4           = 0,
    parameter int unsigned COLS           = 16,
    parameter int unsigned LINES          = 2,
    parameter int unsigned EN_HIGH_CYC    = 12,
    parameter int unsigned CMD_WAIT_CYC   = 2000,
    parameter int unsigned CLEAR_WAIT_CYC = 82000,
    parameter int unsigned POWERUP_CYC    = 750000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_rs,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data,
    output logic [3:0] debug
);

    localparam int unsigned MAX_AB  = (EN_HIGH_CYC > CMD_WAIT_CYC) ? EN_HIGH_CYC : CMD_WAIT_CYC;
    localparam int unsigned MAX_CD  = (CLEAR_WAIT_CYC > POWERUP_CYC) ? CLEAR_WAIT_CYC : POWERUP_CYC;
    localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned N_INIT  = (BUS4 != 0) ? 6 : 5;
    localparam logic [7:0]  FSET    = (BUS4 != 0) ? 8'h28 : 8'h38;

    typedef enum logic [3:0] {
        S_PWRUP  = 4'd0,
        S_INIT   = 4'd1,
        S_IDLE   = 4'd2,
        S_SETUP  = 4'd3,
        S_STROBE = 4'd4,
        S_GAP    = 4'd5,
        S_WAIT   = 4'd6,
        S_WRAP   = 4'd7
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    init_idx, init_idx_d;
    logic [7:0]    cur_byte, cur_byte_d;
    logic          cur_rs, cur_rs_d;
    logic          single, single_d;
    logic          lo_phase, lo_phase_d;
    logic          line, line_d;
    logic [5:0]    col, col_d;
    logic          init_done_d, ready_d, en_d, rs_d;
    logic [7:0]    data_d;
    logic [31:0]   limit;
    logic          cnt_last;
    logic          is_clear;

    // Index 0 of the 4-bit sequence is the lone 0x2 nibble that switches the bus width
    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        logic [2:0] k;
        k = (BUS4 != 0) ? idx - 3'd1 : idx;
        if (BUS4 != 0 && idx == 3'd0) return 8'h20;
        case (k)
            3'd0:    return FSET;
            3'd1:    return 8'h0E;
            3'd2:    return 8'h01;
            3'd3:    return 8'h06;
            default: return 8'h80;
        endcase
    endfunction

    function automatic logic [7:0] hi_bus(input logic [7:0] b);
        return (BUS4 != 0) ? {b[7:4], 4'h0} : b;
    endfunction

    function automatic logic [7:0] lo_bus(input logic [7:0] b);
        return {b[3:0], 4'h0};
    endfunction

    assign lcd_rw   = 1'b0;
    assign debug    = state;
    assign is_clear = !cur_rs && (cur_byte == 8'h01 || cur_byte == 8'h02);

    always_comb begin
        case (state)
            S_PWRUP:         limit = POWERUP_CYC;
            S_STROBE, S_GAP: limit = EN_HIGH_CYC;
            S_WAIT:          limit = is_clear ? CLEAR_WAIT_CYC : CMD_WAIT_CYC;
            default:         limit = 32'd1;
        endcase
    end

    assign cnt_last = (32'(cnt) + 32'd1 >= limit);

    // Next state plus next values of the registered pin/handshake outputs
    always_comb begin
        state_d     = state;
        cnt_d       = '0;
        init_idx_d  = init_idx;
        cur_byte_d  = cur_byte;
        cur_rs_d    = cur_rs;
        single_d    = single;
        lo_phase_d  = lo_phase;
        line_d      = line;
        col_d       = col;
        init_done_d = init_done;
        ready_d     = 1'b0;
        en_d        = 1'b0;
        rs_d        = lcd_rs;
        data_d      = lcd_data;
        case (state)
            S_PWRUP: begin
                if (cnt_last) state_d = S_INIT;
                else          cnt_d   = cnt + CW'(1);
            end
            S_INIT: begin
                if (init_idx == 3'(N_INIT)) begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                    ready_d     = 1'b1;
                    line_d      = 1'b0;
                    col_d       = 6'd0;
                end else begin
                    state_d    = S_SETUP;
                    cur_byte_d = init_byte(init_idx);
                    cur_rs_d   = 1'b0;
                    single_d   = (BUS4 != 0) && (init_idx == 3'd0);
                    lo_phase_d = 1'b0;
                    init_idx_d = init_idx + 3'd1;
                    rs_d       = 1'b0;
                    data_d     = hi_bus(init_byte(init_idx));
                end
            end
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    state_d    = S_SETUP;
                    cur_byte_d = in_data;
                    cur_rs_d   = in_rs;
                    single_d   = 1'b0;
                    lo_phase_d = 1'b0;
                    rs_d       = in_rs;
                    data_d     = hi_bus(in_data);
                end else begin
                    ready_d = init_done;
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
                en_d    = 1'b1;
            end
            S_STROBE: begin
                if (cnt_last) begin
                    state_d = (BUS4 != 0 && !single && !lo_phase) ? S_GAP : S_WAIT;
                end else begin
                    cnt_d = cnt + CW'(1);
                    en_d  = 1'b1;
                end
            end
            S_GAP: begin
                // Upper nibble stays on the pins for the first gap cycle (hold time)
                data_d = lo_bus(cur_byte);
                if (cnt_last) begin
                    state_d    = S_STROBE;
                    en_d       = 1'b1;
                    lo_phase_d = 1'b1;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_WAIT: begin
                if (cnt_last) begin
                    if (cur_rs) begin
                        col_d = col + 6'd1;
                    end else if (is_clear) begin
                        line_d = 1'b0;
                        col_d  = 6'd0;
                    end else if (cur_byte[7]) begin
                        line_d = (LINES > 1) ? cur_byte[6] : 1'b0;
                        col_d  = cur_byte[5:0];
                    end
                    if (!init_done) begin
                        state_d = S_INIT;
                    end else if (cur_rs && (32'(col) + 32'd1 >= COLS)) begin
                        state_d = S_WRAP;
                    end else begin
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_WRAP: begin
                // Cursor itself is updated when the issued set-DDRAM command finishes
                state_d    = S_SETUP;
                cur_byte_d = ((LINES > 1) && !line) ? 8'hC0 : 8'h80;
                cur_rs_d   = 1'b0;
                single_d   = 1'b0;
                lo_phase_d = 1'b0;
                rs_d       = 1'b0;
                data_d     = hi_bus(((LINES > 1) && !line) ? 8'hC0 : 8'h80);
            end
            default: state_d = S_PWRUP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_PWRUP;
            cnt       <= '0;
            init_idx  <= 3'd0;
            cur_byte  <= 8'h00;
            cur_rs    <= 1'b0;
            single    <= 1'b0;
            lo_phase  <= 1'b0;
            line      <= 1'b0;
            col       <= 6'd0;
            init_done <= 1'b0;
            in_ready  <= 1'b0;
            lcd_en    <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            init_idx  <= init_idx_d;
            cur_byte  <= cur_byte_d;
            cur_rs    <= cur_rs_d;
            single    <= single_d;
            lo_phase  <= lo_phase_d;
            line      <= line_d;
            col       <= col_d;
            init_done <= init_done_d;
            in_ready  <= ready_d;
            lcd_en    <= en_d;
            lcd_rs    <= rs_d;
            lcd_data  <= data_d;
        end
    end

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Directed bench for lcd_char_ctrl: one 8-bit instance (COLS=4) and one 4-bit instance.
module tb_lcd_char_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8_n, in_rs8, in_valid8, in_ready8, init_done8, lcd_rs8, lcd_rw8, lcd_en8;
    logic [7:0] in_data8, lcd_data8;
    logic [3:0] debug8;
    logic       rst4_n, in_rs4, in_valid4, in_ready4, init_done4, lcd_rs4, lcd_rw4, lcd_en4;
    logic [7:0] in_data4, lcd_data4;
    logic [3:0] debug4;

    lcd_char_ctrl #(
        .BUS4(0), .COLS(4), .LINES(2), .EN_HIGH_CYC(3),
        .CMD_WAIT_CYC(10), .CLEAR_WAIT_CYC(30), .POWERUP_CYC(50)
    ) u_dut8 (
        .clk(clk), .rst_n(rst8_n), .in_data(in_data8), .in_rs(in_rs8),
        .in_valid(in_valid8), .in_ready(in_ready8), .init_done(init_done8),
        .lcd_rs(lcd_rs8), .lcd_rw(lcd_rw8), .lcd_en(lcd_en8),
        .lcd_data(lcd_data8), .debug(debug8)
    );

    lcd_char_ctrl #(
        .BUS4(1), .COLS(16), .LINES(2), .EN_HIGH_CYC(3),
        .CMD_WAIT_CYC(10), .CLEAR_WAIT_CYC(30), .POWERUP_CYC(50)
    ) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .in_data(in_data4), .in_rs(in_rs4),
        .in_valid(in_valid4), .in_ready(in_ready4), .init_done(init_done4),
        .lcd_rs(lcd_rs4), .lcd_rw(lcd_rw4), .lcd_en(lcd_en4),
        .lcd_data(lcd_data4), .debug(debug4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Strobe monitor on the selected instance, sampled on the falling clock edge
    logic       sel4 = 1'b0;
    logic       mon_en, mon_rs;
    logic [7:0] mon_data;
    assign mon_en   = sel4 ? lcd_en4   : lcd_en8;
    assign mon_rs   = sel4 ? lcd_rs4   : lcd_rs8;
    assign mon_data = sel4 ? lcd_data4 : lcd_data8;

    logic [7:0] q_data[$];
    logic       q_rs[$];
    logic       q_stab[$];
    int         q_hi[$];
    int         q_gap[$];
    int         lo_run  = 0;
    int         hi_run  = 0;
    logic       prev_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en && !prev_en) begin
            q_data.push_back(mon_data);
            q_rs.push_back(mon_rs);
            q_gap.push_back(lo_run);
            hi_run = 1;
        end else if (mon_en) begin
            hi_run++;
        end else if (prev_en) begin
            q_hi.push_back(hi_run);
            q_stab.push_back(q_data.size() > 0 && mon_data == q_data[$] && mon_rs == q_rs[$]);
            lo_run = 1;
        end else begin
            lo_run++;
        end
        prev_en = mon_en;
    end

    task automatic clear_mon();
        q_data.delete(); q_rs.delete(); q_stab.delete(); q_hi.delete(); q_gap.delete();
        lo_run = 0;
    endtask

    function automatic logic pick(input int w);
        case (w)
            0:       return init_done8;
            1:       return in_ready8;
            2:       return lcd_en8;
            3:       return init_done4;
            default: return in_ready4;
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int w, input int budget);
        int n = 0;
        while (!pick(w) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!pick(w)) check({"timeout_", tag}, 32'd0, 32'd1);
    endtask

    task automatic send(input int dut, input logic rs, input logic [7:0] d);
        wait_sig("send_ready", (dut == 0) ? 1 : 4, 300);
        if (dut == 0) begin in_valid8 = 1'b1; in_rs8 = rs; in_data8 = d; end
        else          begin in_valid4 = 1'b1; in_rs4 = rs; in_data4 = d; end
        @(posedge clk);
        #1;
        if (dut == 0) in_valid8 = 1'b0;
        else          in_valid4 = 1'b0;
    endtask

    logic [7:0] exp_init8[5]  = '{8'h38, 8'h0E, 8'h01, 8'h06, 8'h80};
    logic [7:0] exp_init4[11] = '{8'h20, 8'h20, 8'h80, 8'h00, 8'hE0, 8'h00,
                                  8'h10, 8'h00, 8'h60, 8'h80, 8'h00};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst8_n = 1'b0; in_rs8 = 1'b0; in_valid8 = 1'b0; in_data8 = 8'h00;
        rst4_n = 1'b0; in_rs4 = 1'b0; in_valid4 = 1'b0; in_data4 = 8'h00;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_en",    32'(lcd_en8),    32'd0);
        check("rst_rs",    32'(lcd_rs8),    32'd0);
        check("rst_rw",    32'(lcd_rw8),    32'd0);
        check("rst_data",  32'(lcd_data8),  32'h00);
        check("rst_ready", 32'(in_ready8),  32'd0);
        check("rst_done",  32'(init_done8), 32'd0);
        check("rst_debug", 32'(debug8),     32'd0);
        check("rst4_data", 32'(lcd_data4),  32'h00);

        // 8-bit init sequence
        rst8_n = 1'b1;
        clear_mon();
        wait_sig("init8", 0, 1000);
        check("init_count", 32'(q_data.size()), 32'd5);
        for (int i = 0; i < 5 && i < q_data.size(); i++) begin
            check($sformatf("init_byte%0d", i), 32'(q_data[i]), 32'(exp_init8[i]));
            check($sformatf("init_rs%0d", i),   32'(q_rs[i]),   32'd0);
        end
        if (q_gap.size() > 3) check("clear_wait_ge30", 32'(q_gap[3] >= 30), 32'd1);
        if (q_gap.size() > 0) check("pwrup_ge50", 32'(q_gap[0] >= 50), 32'd1);
        check("init_ready", 32'(in_ready8), 32'd1);
        check("init_debug", 32'(debug8),    32'd2);

        // Single data write 0x41
        clear_mon();
        send(0, 1'b1, 8'h41);
        @(negedge clk);
        check("setup_debug", 32'(debug8),    32'd3);
        check("setup_rs",    32'(lcd_rs8),   32'd1);
        check("setup_data",  32'(lcd_data8), 32'h41);
        check("setup_en",    32'(lcd_en8),   32'd0);
        check("setup_ready", 32'(in_ready8), 32'd0);
        n = 1;
        while (!in_ready8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_latency", 32'(n), 32'd15);
        if (q_hi.size() > 0) check("en_high_cycles", 32'(q_hi[0]), 32'd3);
        if (q_stab.size() > 0) check("hold_after_fall", 32'(q_stab[0]), 32'd1);

        // Fill line 0 -> wrap to line 1, then fill line 1 -> wrap to line 0
        send(0, 1'b1, 8'h42); send(0, 1'b1, 8'h43); send(0, 1'b1, 8'h44);
        wait_sig("wrap1", 1, 300);
        check("wrap1_count", 32'(q_data.size()), 32'd5);
        if (q_data.size() > 4) begin
            check("wrap1_data", 32'(q_data[4]), 32'hC0);
            check("wrap1_rs",   32'(q_rs[4]),   32'd0);
            check("char4_data", 32'(q_data[3]), 32'h44);
        end
        clear_mon();
        for (int i = 0; i < 4; i++) send(0, 1'b1, 8'(8'h45 + i));
        wait_sig("wrap2", 1, 300);
        check("wrap2_count", 32'(q_data.size()), 32'd5);
        if (q_data.size() > 4) begin
            check("wrap2_data", 32'(q_data[4]), 32'h80);
            check("wrap2_rs",   32'(q_rs[4]),   32'd0);
        end

        // in_valid held high across three requests
        clear_mon();
        in_rs8 = 1'b1; in_data8 = 8'h31; in_valid8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_sig("stream", 1, 300);
            @(posedge clk);
            #1;
            in_data8 = 8'(8'h32 + i);
        end
        in_valid8 = 1'b0;
        wait_sig("stream_end", 1, 300);
        repeat (5) @(negedge clk);
        check("stream_count", 32'(q_data.size()), 32'd3);
        for (int i = 0; i < 3 && i < q_data.size(); i++)
            check($sformatf("stream_byte%0d", i), 32'(q_data[i]), 32'(8'h31 + i));

        // Reset during a strobe
        send(0, 1'b1, 8'h5A);
        wait_sig("en_high", 2, 50);
        #2;
        rst8_n = 1'b0;
        #1;
        check("abort_en",    32'(lcd_en8),    32'd0);
        check("abort_debug", 32'(debug8),     32'd0);
        check("abort_data",  32'(lcd_data8),  32'h00);
        check("abort_done",  32'(init_done8), 32'd0);
        @(negedge clk);
        rst8_n = 1'b1;
        clear_mon();
        wait_sig("reinit8", 0, 1000);
        check("reinit_count", 32'(q_data.size()), 32'd5);
        if (q_data.size() > 4) begin
            check("reinit_first", 32'(q_data[0]), 32'h38);
            check("reinit_last",  32'(q_data[4]), 32'h80);
        end
        if (q_gap.size() > 0) check("reinit_pwrup_ge50", 32'(q_gap[0] >= 50), 32'd1);

        // 4-bit instance
        sel4 = 1'b1;
        @(negedge clk);
        rst4_n = 1'b1;
        clear_mon();
        wait_sig("init4", 3, 2000);
        check("init4_count", 32'(q_data.size()), 32'd11);
        for (int i = 0; i < 11 && i < q_data.size(); i++)
            check($sformatf("init4_nib%0d", i), 32'(q_data[i]), 32'(exp_init4[i]));
        clear_mon();
        send(1, 1'b1, 8'h41);
        wait_sig("nib_done", 4, 300);
        check("nib_count", 32'(q_data.size()), 32'd2);
        if (q_data.size() > 1) begin
            check("nib_hi",     32'(q_data[0]),      32'h40);
            check("nib_lo",     32'(q_data[1]),      32'h10);
            check("nib_low0",   32'(q_data[0][3:0]), 32'h0);
            check("nib_low1",   32'(q_data[1][3:0]), 32'h0);
            check("nib_rs",     32'(q_rs[0] & q_rs[1]), 32'd1);
            check("nib_gap",    32'(q_gap[1]),       32'd3);
            check("nib_hi_len", 32'(q_hi[1]),        32'd3);
        end
        check("nib_rw", 32'(lcd_rw4), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
